// File: rtl/syncfifo_rd_stream_if.sv
// Bundle between a non-FWFT syncfifo read port, the read-stream adapter and
// its downstream consumer. The adapter takes the master side.
interface syncfifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [1:0]            buf_cnt;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, buf_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, buf_cnt
  );
endinterface

// File: rtl/syncfifo_rd_stream.sv
// Read-side adapter for a syncfifo with one cycle of read latency. A 2-entry
// prefetch buffer absorbs that latency so the valid/ready stream can move one
// word per cycle without ever reading an empty FIFO.
module syncfifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  syncfifo_rd_stream_if.master bus
);

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic                  r_inflight;
  logic [1:0]            r_cnt;

  logic                  w_valid;
  logic                  w_pop;
  logic [1:0]            w_occ;
  logic                  w_rd_en;

  // Issue a read whenever the word it returns is guaranteed a buffer slot:
  // either buffered + in-flight is below 2, or a pop frees a slot this cycle.
  always_comb begin
    w_valid = (r_cnt != 2'd0);
    w_pop   = w_valid & bus.m_ready;
    w_occ   = r_cnt + {1'b0, r_inflight};
    w_rd_en = ~rst & ~bus.fifo_empty & ((w_occ < 2'd2) | w_pop);
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_buf[r_rd_ptr];
  assign bus.buf_cnt    = r_cnt;

  // Capture returning read data, advance pointers and track occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      // cnt + inflight <= 2 guarantees the target slot is free here.
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= bus.fifo_dout;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_inflight <= w_rd_en;
      r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_syncfifo_rd_stream.sv
// Directed and random bench for syncfifo_rd_stream against a behavioural
// 16-deep non-FWFT FIFO, with an in-order scoreboard on the stream side.
module tb_syncfifo_rd_stream;

  localparam int unsigned DW    = 16;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  syncfifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  syncfifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO model state and stimulus
  logic [DW-1:0] fq [$];
  logic [DW-1:0] exp_q [$];
  logic          f_empty   = 1'b1;
  logic [DW-1:0] f_dout    = '0;
  logic          f_wr_en   = 1'b0;
  logic [DW-1:0] f_wr_data = '0;
  logic          r_ready   = 1'b0;
  int unsigned   rd_cnt    = 0;
  int unsigned   beats     = 0;

  int unsigned   checks = 0;
  int unsigned   errors = 0;

  assign bus.fifo_dout  = f_dout;
  assign bus.fifo_empty = f_empty;
  assign bus.m_ready    = r_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Non-FWFT FIFO: data one cycle after rd_en, registered empty, writes drop when full.
  always @(posedge clk) begin
    int unsigned n0;
    n0 = fq.size();
    if (bus.fifo_rd_en && n0 != 0) begin
      f_dout <= fq.pop_front();
      rd_cnt++;
    end
    if (f_wr_en && n0 < Depth) begin
      fq.push_back(f_wr_data);
      exp_q.push_back(f_wr_data);
    end
    f_empty <= (fq.size() == 0);
  end

  // Stream monitor: scoreboard, invariants, reset outputs and stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    check("rd_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
    check("buf_cnt_le2", 32'(bus.buf_cnt <= 2'd2), 32'd1);
    if (rst) begin
      check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_data", 32'(bus.m_data), 32'd0);
      check("rst_buf_cnt", 32'(bus.buf_cnt), 32'd0);
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        beats++;
        if (exp_q.size() == 0) check("unexpected_beat", 32'(bus.m_data), 32'hffff_ffff);
        else check("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    f_wr_en   = 1'b1;
    f_wr_data = d;
    step();
    f_wr_en   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 300) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle_valid"}, 32'(bus.m_valid), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, 32'(bus.m_valid), 32'd1);
  endtask

  int unsigned nxt;
  int unsigned cyc;
  int unsigned rd0;
  int unsigned b0;

  initial begin
    // Reset held while the FIFO fills with 4 words, then 3 more cycles.
    step();
    for (int i = 0; i < 4; i++) write_word(DW'(16'h11 + i));
    for (int i = 0; i < 3; i++) step();
    r_ready = 1'b1;
    rst = 1'b0;
    wait_valid("reset");
    check("reset_first_word", 32'(bus.m_data), 32'h11);
    drain("reset");

    // Burst: 1..20 written with the adapter held in reset; 16 accepted.
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) write_word(DW'(i));
    check("burst_accepted", 32'(exp_q.size()), 32'd16);
    rst = 1'b0;
    @(negedge clk);
    check("burst_rd_en_T", 32'(bus.fifo_rd_en), 32'd1);
    check("burst_valid_T", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("burst_valid_T1", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("burst_valid_T2", 32'(bus.m_valid), 32'd1);
    check("burst_first", 32'(bus.m_data), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      check("burst_consecutive", 32'(bus.m_valid), 32'd1);
      check("burst_data", 32'(bus.m_data), 32'(i));
    end
    @(negedge clk);
    check("burst_end_valid", 32'(bus.m_valid), 32'd0);
    step();
    drain("burst");

    // Backpressure: 1..5 with m_ready low.
    r_ready = 1'b0;
    rd0 = rd_cnt;
    for (int i = 1; i <= 5; i++) write_word(DW'(i));
    for (int i = 0; i < 8; i++) step();
    check("bp_reads", rd_cnt - rd0, 32'd2);
    check("bp_buf_cnt", 32'(bus.buf_cnt), 32'd2);
    check("bp_hold_data", 32'(bus.m_data), 32'd1);
    check("bp_rd_en_low", 32'(bus.fifo_rd_en), 32'd0);
    r_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("bp_consecutive", 32'(bus.m_valid), 32'd1);
      check("bp_data", 32'(bus.m_data), 32'(i));
    end
    step();
    drain("bp");

    // Single word: startup latency, then idle.
    write_word(DW'(16'hA5));
    @(negedge clk);
    check("single_empty_fell", 32'(bus.fifo_empty), 32'd0);
    check("single_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    check("single_valid_T", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("single_valid_T1", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("single_valid_T2", 32'(bus.m_valid), 32'd1);
    check("single_data", 32'(bus.m_data), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("single_idle_valid", 32'(bus.m_valid), 32'd0);
      check("single_idle_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    end
    step();

    // Random writes and 50% m_ready, 1000 incrementing words.
    b0  = beats;
    nxt = 1;
    cyc = 0;
    while (nxt <= 1000 && cyc < 20000) begin
      f_wr_en   = ($urandom_range(0, 1) == 1) && (fq.size() < Depth);
      f_wr_data = DW'(nxt);
      if (f_wr_en) nxt++;
      r_ready = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
    end
    f_wr_en = 1'b0;
    r_ready = 1'b1;
    check("rand_all_written", nxt, 32'd1001);
    drain("rand");
    check("rand_beats", beats - b0, 32'd1000);

    // Reset mid-transfer with two words buffered.
    r_ready = 1'b0;
    for (int i = 1; i <= 8; i++) write_word(DW'(i));
    for (int i = 0; i < 6; i++) step();
    check("mid_buf_cnt", 32'(bus.buf_cnt), 32'd2);
    check("mid_data", 32'(bus.m_data), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_data", 32'(bus.m_data), 32'd0);
    check("mid_rst_cnt", 32'(bus.buf_cnt), 32'd0);
    check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    // Buffered words are discarded; the stream resumes from the FIFO.
    exp_q = fq;
    step();
    step();
    r_ready = 1'b1;
    rst = 1'b0;
    wait_valid("mid");
    check("mid_resume_word", 32'(bus.m_data), 32'd3);
    drain("mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syncfifo_rd_stream.md
# syncfifo_rd_stream

Read-side adapter placed directly downstream of `syncfifo` configured with `FWFT_EN = 0`. It drives the FIFO's `rd_en` and absorbs the one-cycle read latency in a 2-entry prefetch buffer. It presents the data as a valid/ready stream that sustains one word per cycle. It never reads an empty FIFO and never drops or duplicates a word.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the upstream `syncfifo` `DATA_WIDTH`.
- `clk`  in  1: single clock, shared with the upstream `syncfifo`.
- `rst`  in  1: asynchronous, active-high reset.
- `fifo_dout`  in  DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1: FIFO empty flag, registered inside the FIFO.
- `fifo_rd_en`  out  1: FIFO read strobe (combinational).
- `m_data`  out  DATA_WIDTH: stream data.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: downstream accept.
- `buf_cnt`  out  2: number of words held in the prefetch buffer (0..2).

## Operation
- State:
  - `buf[0:1]`, DATA_WIDTH each.
  - 1-bit `wr_ptr` and `rd_ptr`.
  - `cnt` (0..2).
  - `inflight` flag: a read was issued last cycle and its data is on `fifo_dout` this cycle.
- `pop = m_valid & m_ready`.
- Read issue: `fifo_rd_en = ~rst & ~fifo_empty & ((cnt + inflight < 2) | pop)`.
- Invariant: `cnt + inflight <= 2` at all times.
- Capture: when `inflight` = 1, write `fifo_dout` into `buf[wr_ptr]` and toggle `wr_ptr`.
- Pop: on `pop`, toggle `rd_ptr`.
- `inflight` next = `fifo_rd_en`.
- `cnt` next = `cnt + inflight - pop`.
- `m_valid = (cnt != 0)`.
- `m_data = buf[rd_ptr]`.
- `buf_cnt = cnt`.
- Stream rule: while `m_valid & ~m_ready`, `m_data` and `m_valid` stay stable.
- Boundary: `cnt = 2` implies `inflight = 0`, so a capture never meets a full buffer.
- Boundary: capture and pop in the same cycle with `cnt = 1` leaves `cnt = 1` and moves both pointers.
- Boundary: with `cnt = 0`, pop is impossible because `m_valid = 0`.
- Boundary: the 1-bit pointers wrap naturally.
- Underflow safety: `fifo_rd_en` is gated by `fifo_empty`. The FIFO's `empty` updates after each read, so the adapter never issues a read on the final-word cycle plus one.
- Reset values (asynchronous, immediate):
  - `cnt = 0`, `inflight = 0`, `wr_ptr = rd_ptr = 0`, `buf` = 0.
  - Outputs: `m_valid = 0`, `m_data = 0`, `buf_cnt = 0`, `fifo_rd_en = 0`.
- Reset mid-operation: buffered and in-flight words are discarded. After release the adapter resumes from the FIFO's next unread word. Words are lost across reset by design; the whole FIFO path is expected to be reset together.

## Timing
- Startup latency: `fifo_empty` falls in cycle T with `cnt = 0` → `fifo_rd_en` = 1 in T → data on `fifo_dout` in T+1 → `m_valid` = 1 in T+2.
- Throughput: 1 word/cycle whenever the FIFO is non-empty and `m_ready` = 1. Steady state is `cnt = 1`, `inflight = 1`, with a read issued and a word popped every cycle.
- Backpressure: when `m_ready` drops, at most 2 more words are read into the buffer, then `fifo_rd_en` stays low.
- Backpressure release: when `m_ready` returns, the buffered word is available the same cycle and the read resumes that cycle.
- `fifo_rd_en` is combinational from `fifo_empty`, `m_ready`, and registered state. There is no combinational path from `fifo_dout` to any output.

## Test plan
- Reset: hold `rst` for 3 cycles with the FIFO holding 4 words → `fifo_rd_en`, `m_valid`, `m_data`, `buf_cnt` all 0 throughout; after release, first `m_data` = first FIFO word.
- Burst: write 1..20 into a 16-deep FIFO (16 accepted), `m_ready` = 1 → `m_data` = 1..16 on 16 consecutive `m_valid` cycles, first beat 2 cycles after `fifo_empty` falls, `fifo_rd_en` never high while `fifo_empty` = 1.
- Backpressure: FIFO holds 1..5, `m_ready` = 0 → exactly 2 reads, `buf_cnt` = 2, `m_data` = 1 held stable. Then `m_ready` = 1 → 1..5 on consecutive cycles.
- Single word: FIFO receives one word 0xA5, `m_ready` = 1 → one beat with `m_data` = 0xA5, then `m_valid` = 0 and `fifo_rd_en` = 0 until the next write.
- Random: 1000 incrementing words, random `wr_en` and random 50% `m_ready` → output in order with no loss or duplication, `buf_cnt` ≤ 2, no read while empty.
- Reset mid-transfer: assert `rst` with `buf_cnt` = 2 and the FIFO holding 1..8 (words 1..2 buffered, word 3 still in FIFO) → outputs go to 0 immediately; after release the stream resumes at the FIFO's next unread word (3) and stays in order.
